// File: rtl/matcher_scheduler_if.sv
// Request/response and matcher-side signals of the matcher scheduler.
// The scheduler connects through the slave modport; its environment uses master.
interface matcher_scheduler_if #(
  parameter int NUM_REQ     = 4,
  parameter int WORD_LENGTH = 3,
  parameter int DATA_WIDTH  = 8
);
  localparam int WORD_W = WORD_LENGTH * DATA_WIDTH;
  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*WORD_W-1:0] req_word;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        resp_valid;
  logic                      resp_found;
  logic                      resp_timeout;
  logic                      m_cs;
  logic [WORD_W-1:0]         m_word;
  logic                      m_done;
  logic                      m_found;
  logic                      busy;
  logic [ID_W-1:0]           grant_id;

  modport slave (
    input  req_valid, req_word, m_done, m_found,
    output req_ready, resp_valid, resp_found, resp_timeout,
           m_cs, m_word, busy, grant_id
  );

  modport master (
    output req_valid, req_word, m_done, m_found,
    input  req_ready, resp_valid, resp_found, resp_timeout,
           m_cs, m_word, busy, grant_id
  );
endinterface

// File: rtl/matcher_scheduler.sv
// Round-robin scheduler that shares one word matcher between NUM_REQ requesters,
// bounding each search with a timeout and returning a one-cycle response strobe.
module matcher_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int WORD_LENGTH    = 3,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                clk,
  input  logic                rst,
  matcher_scheduler_if.slave  bus
);

  localparam int WORD_W = WORD_LENGTH * DATA_WIDTH;
  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W  = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, SEARCH, RESPOND} state_t;

  state_t            state, next_state;
  logic [ID_W-1:0]   last_grant, grant_q, winner, cand;
  logic              win_valid, accept, timed_out;
  logic [CNT_W-1:0]  count;
  logic [WORD_W-1:0] word_q, sel_word;
  logic              found_q, timeout_q;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    winner    = last_grant;
    win_valid = 1'b0;
    cand      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = ID_W'((int'(last_grant) + i) % NUM_REQ);
      if (!win_valid && bus.req_valid[cand]) begin
        win_valid = 1'b1;
        winner    = cand;
      end
    end
  end

  always_comb begin
    sel_word = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == ID_W'(i)) sel_word = bus.req_word[i*WORD_W +: WORD_W];
    end
  end

  assign accept    = (state == IDLE) && win_valid;
  assign timed_out = (count == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (win_valid) next_state = SEARCH;
      SEARCH:  if (bus.m_done || timed_out) next_state = RESPOND;
      RESPOND: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready  = '0;
    bus.resp_valid = '0;
    bus.m_cs       = 1'b0;
    bus.busy       = 1'b1;
    case (state)
      IDLE: begin
        bus.busy = 1'b0;
        if (win_valid) bus.req_ready = NUM_REQ'(1) << winner;
      end
      SEARCH:  bus.m_cs = 1'b1;
      RESPOND: bus.resp_valid = NUM_REQ'(1) << grant_q;
      default: ;
    endcase
  end

  // A matcher completion takes precedence over a timeout landing on the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= ID_W'(NUM_REQ - 1);
      grant_q    <= '0;
      word_q     <= '0;
      count      <= '0;
      found_q    <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      if (accept) begin
        word_q     <= sel_word;
        last_grant <= winner;
        grant_q    <= winner;
        count      <= '0;
      end
      if (state == SEARCH) begin
        count <= count + 1'b1;
        if (bus.m_done) begin
          found_q   <= bus.m_found;
          timeout_q <= 1'b0;
        end else if (timed_out) begin
          found_q   <= 1'b0;
          timeout_q <= 1'b1;
        end
      end
    end
  end

  assign bus.m_word       = word_q;
  assign bus.grant_id     = grant_q;
  assign bus.resp_found   = found_q;
  assign bus.resp_timeout = timeout_q;

endmodule

// File: tb/tb_matcher_scheduler.sv
// Self-checking bench for matcher_scheduler: a transaction table with a response
// scoreboard, plus hand sequences for reset-in-flight and stray matcher strobes.
module tb_matcher_scheduler;

  localparam int NUM_REQ     = 4;
  localparam int WORD_LENGTH = 3;
  localparam int DATA_WIDTH  = 8;
  localparam int TIMEOUT     = 8;
  localparam int WORD_W      = WORD_LENGTH * DATA_WIDTH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  matcher_scheduler_if #(.NUM_REQ(NUM_REQ), .WORD_LENGTH(WORD_LENGTH), .DATA_WIDTH(DATA_WIDTH)) bus ();

  matcher_scheduler #(
    .NUM_REQ(NUM_REQ), .WORD_LENGTH(WORD_LENGTH),
    .DATA_WIDTH(DATA_WIDTH), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic               rst_first;
    logic [NUM_REQ-1:0] valid;
    logic [WORD_W-1:0]  word;
    int                 latency;
    logic               found;
    int                 exp_id;
    logic               exp_found;
    logic               exp_timeout;
    int                 exp_cs;
  } vec_t;

  typedef struct {
    int                id;
    logic              found;
    logic              timeout;
    logic [WORD_W-1:0] word;
    int                cs;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   failed = 0;
  int   cs_count = 0;
  int   last_cs_run = 0;
  int   mdl_latency = 0;
  logic mdl_found = 1'b0;
  logic stray_done = 1'b0;
  logic resp_seen = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  // One clock: the matcher model raises m_done after mdl_latency cs-high cycles
  // (0 = never), and any response strobe is matched against the scoreboard.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (!bus.m_cs && cs_count != 0) last_cs_run = cs_count;
    cs_count    = bus.m_cs ? cs_count + 1 : 0;
    bus.m_done  = stray_done || (bus.m_cs && mdl_latency != 0 && cs_count == mdl_latency);
    bus.m_found = mdl_found;
    if (bus.resp_valid != '0) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_resp", 32'(bus.resp_valid), 32'h0);
      end else begin
        e = sb.pop_front();
        resp_seen = 1'b1;
        checkOutput("resp_valid", 32'(bus.resp_valid), 32'(1) << e.id);
        checkOutput("resp_found", 32'(bus.resp_found), 32'(e.found));
        checkOutput("resp_timeout", 32'(bus.resp_timeout), 32'(e.timeout));
        checkOutput("cs_cycles", 32'(last_cs_run), 32'(e.cs));
        checkOutput("m_word_hold", 32'(bus.m_word), 32'(e.word));
      end
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    logic [NUM_REQ*WORD_W-1:0] w;
    for (int i = 0; i < NUM_REQ; i++) w[i*WORD_W +: WORD_W] = WORD_W'(32'hA0A0A0 + i * 32'h010101);
    w[v.exp_id*WORD_W +: WORD_W] = v.word;
    bus.req_word  = w;
    bus.req_valid = v.valid;
    mdl_latency   = v.latency;
    mdl_found     = v.found;
  endtask

  task automatic doReset();
    rst = 1'b1;
    bus.req_valid = '0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic runTxn(input vec_t v);
    exp_t e;
    int   n;
    if (v.rst_first) doReset();
    applyStimulus(v);
    #1;
    checkOutput("req_ready", 32'(bus.req_ready), 32'(1) << v.exp_id);
    e.id = v.exp_id; e.found = v.exp_found; e.timeout = v.exp_timeout;
    e.word = v.word; e.cs = v.exp_cs;
    sb.push_back(e);
    tick();
    checkOutput("m_cs_rise", 32'(bus.m_cs), 32'h1);
    checkOutput("busy_search", 32'(bus.busy), 32'h1);
    checkOutput("grant_id", 32'(bus.grant_id), 32'(v.exp_id));
    checkOutput("m_word_latch", 32'(bus.m_word), 32'(v.word));
    checkOutput("ready_in_search", 32'(bus.req_ready), 32'h0);
    bus.req_word = ~bus.req_word;
    resp_seen = 1'b0;
    n = 0;
    while (!resp_seen && n < TIMEOUT + 4) begin
      tick();
      n++;
    end
    checkOutput("resp_arrived", 32'(resp_seen), 32'h1);
    tick();
    checkOutput("resp_one_cycle", 32'(bus.resp_valid), 32'h0);
    checkOutput("busy_after", 32'(bus.busy), 32'h0);
  endtask

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t vecs[11];
    vec_t v;

    vecs[0]  = '{1'b0, 4'b0001, 24'h48656C, 5, 1'b1, 0, 1'b1, 1'b0, 5};
    vecs[1]  = '{1'b1, 4'b1111, 24'h111111, 2, 1'b1, 0, 1'b1, 1'b0, 2};
    vecs[2]  = '{1'b0, 4'b1111, 24'h222222, 3, 1'b0, 1, 1'b0, 1'b0, 3};
    vecs[3]  = '{1'b0, 4'b1111, 24'h333333, 1, 1'b1, 2, 1'b1, 1'b0, 1};
    vecs[4]  = '{1'b0, 4'b1111, 24'h444444, 4, 1'b0, 3, 1'b0, 1'b0, 4};
    vecs[5]  = '{1'b0, 4'b1111, 24'h555555, 6, 1'b1, 0, 1'b1, 1'b0, 6};
    vecs[6]  = '{1'b0, 4'b0100, 24'h0ABCDE, 0, 1'b1, 2, 1'b0, 1'b1, 8};
    vecs[7]  = '{1'b0, 4'b0110, 24'h123456, 3, 1'b0, 1, 1'b0, 1'b0, 3};
    vecs[8]  = '{1'b0, 4'b1001, 24'h654321, 8, 1'b1, 3, 1'b1, 1'b0, 8};
    vecs[9]  = '{1'b0, 4'b1001, 24'h777777, 9, 1'b1, 0, 1'b0, 1'b1, 8};
    vecs[10] = '{1'b0, 4'b0010, 24'h010203, 1, 1'b1, 1, 1'b1, 1'b0, 1};

    bus.req_valid = '0;
    bus.req_word  = '0;
    bus.m_done    = 1'b0;
    bus.m_found   = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    checkOutput("rst_busy", 32'(bus.busy), 32'h0);
    checkOutput("rst_m_cs", 32'(bus.m_cs), 32'h0);
    checkOutput("rst_ready", 32'(bus.req_ready), 32'h0);
    checkOutput("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
    checkOutput("rst_resp_found", 32'(bus.resp_found), 32'h0);
    checkOutput("rst_resp_timeout", 32'(bus.resp_timeout), 32'h0);
    checkOutput("rst_grant_id", 32'(bus.grant_id), 32'h0);
    checkOutput("rst_m_word", 32'(bus.m_word), 32'h0);
    rst = 1'b0;
    tick();
    checkOutput("idle_no_valid_ready", 32'(bus.req_ready), 32'h0);

    for (int i = 0; i < 11; i++) runTxn(vecs[i]);

    // Reset on the third search cycle of requester 2 drops the request silently.
    doReset();
    v = '{1'b0, 4'b0100, 24'hDEAD01, 0, 1'b1, 2, 1'b0, 1'b1, 8};
    applyStimulus(v);
    #1;
    checkOutput("s5_ready", 32'(bus.req_ready), 32'h4);
    tick();
    checkOutput("s5_m_cs", 32'(bus.m_cs), 32'h1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    checkOutput("s5_m_cs_low", 32'(bus.m_cs), 32'h0);
    checkOutput("s5_busy", 32'(bus.busy), 32'h0);
    checkOutput("s5_no_resp", 32'(bus.resp_valid), 32'h0);
    checkOutput("s5_grant_id", 32'(bus.grant_id), 32'h0);
    checkOutput("s5_m_word", 32'(bus.m_word), 32'h0);
    rst = 1'b0;
    runTxn('{1'b0, 4'b0101, 24'h0A0B0C, 2, 1'b1, 0, 1'b1, 1'b0, 2});

    // Word changes and a stray matcher strobe while idle must be ignored.
    bus.req_valid = '0;
    bus.req_word  = {NUM_REQ{24'hFFFFFF}};
    stray_done    = 1'b1;
    mdl_found     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("s6_m_word", 32'(bus.m_word), 32'h0A0B0C);
      checkOutput("s6_no_resp", 32'(bus.resp_valid), 32'h0);
      checkOutput("s6_busy", 32'(bus.busy), 32'h0);
      checkOutput("s6_m_cs", 32'(bus.m_cs), 32'h0);
      checkOutput("s6_ready", 32'(bus.req_ready), 32'h0);
    end
    stray_done = 1'b0;
    tick();
    runTxn('{1'b0, 4'b0010, 24'h0C0FFE, 2, 1'b0, 1, 1'b0, 1'b0, 2});

    checkOutput("sb_empty", 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/matcher_scheduler.md
MATCHER_SCHEDULER -- requirements
Module: matcher_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of requesters sharing one matcher.
REQ-002 The block SHALL have parameter WORD_LENGTH, default 3, giving the characters per word.
REQ-003 The block SHALL have parameter DATA_WIDTH, default 8, giving the bits per character.
REQ-004 The block SHALL have parameter TIMEOUT_CYCLES, default 64, giving the maximum search duration in cycles (>=2).
REQ-005 The block SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port req_valid, input, NUM_REQ bits: per-requester request pending.
REQ-008 The block SHALL have port req_word, input, NUM_REQ*WORD_LENGTH*DATA_WIDTH bits: packed words; requester i occupies slice i.
REQ-009 The block SHALL have port req_ready, output, NUM_REQ bits: one-hot accept.
REQ-010 The block SHALL have port resp_valid, output, NUM_REQ bits: one-hot response strobe.
REQ-011 The block SHALL have port resp_found, output, 1 bit: match result, qualified by resp_valid.
REQ-012 The block SHALL have port resp_timeout, output, 1 bit: search aborted, qualified by resp_valid.
REQ-013 The block SHALL have port m_cs, output, 1 bit: matcher chip select.
REQ-014 The block SHALL have port m_word, output, WORD_LENGTH*DATA_WIDTH bits: word presented to the matcher.
REQ-015 The block SHALL have port m_done, input, 1 bit: matcher search complete.
REQ-016 The block SHALL have port m_found, input, 1 bit: matcher hit, valid with m_done.
REQ-017 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-018 The block SHALL have port grant_id, output, $clog2(NUM_REQ) bits: index of the current or last granted requester.

Function
REQ-019 The FSM SHALL have exactly three states: IDLE, SEARCH and RESPOND.
REQ-020 In IDLE with any req_valid set, the block SHALL assert req_ready combinationally for exactly one winner, chosen round-robin starting at last_grant+1 modulo NUM_REQ.
REQ-021 On a valid&ready transfer, the block SHALL latch req_word[winner] into m_word, set last_grant and grant_id to the winner, clear the timeout counter, and enter SEARCH.
REQ-022 req_ready SHALL be all-zero outside IDLE, and SHALL be all-zero in IDLE when req_valid is zero.
REQ-023 In SEARCH, m_cs SHALL be 1, m_word SHALL hold stable, and the counter SHALL increment every cycle.
REQ-024 In SEARCH with m_done=1, the block SHALL capture m_found into resp_found, set resp_timeout=0, and enter RESPOND.
REQ-025 In SEARCH with m_done=0 and counter == TIMEOUT_CYCLES-1, the block SHALL set resp_found=0 and resp_timeout=1, and enter RESPOND.
REQ-026 If m_done and timeout occur in the same cycle, m_done SHALL win.
REQ-027 In RESPOND, the block SHALL drive resp_valid[grant_id]=1 for exactly one cycle and m_cs=0, then unconditionally enter IDLE.
REQ-028 m_cs SHALL be 0 in IDLE and RESPOND, guaranteeing at least 2 cs-low cycles between consecutive searches so that the matcher restarts.
REQ-029 m_done and m_found SHALL be ignored outside SEARCH.
REQ-030 Latency: with an accept in cycle T and m_done sampled in cycle D, m_cs SHALL rise at T+1, resp_valid SHALL assert at D+1, and the earliest next accept SHALL be at D+2.
REQ-031 A requester that drops req_valid before its grant SHALL be skipped with no side effects.
REQ-032 req_word SHALL be sampled only at the accept cycle; later changes to it SHALL have no effect.

Reset
REQ-033 When rst=1 at a clock edge, the state SHALL become IDLE and m_cs, req_ready, resp_valid, resp_found, resp_timeout, busy and the counter SHALL all be 0.
REQ-034 On reset, m_word SHALL be cleared to 0, grant_id to 0, and last_grant to NUM_REQ-1, so that requester 0 has first priority.
REQ-035 A reset during SEARCH or RESPOND SHALL discard the in-flight request with no response, and m_cs SHALL be low from the next cycle.

Verification
REQ-036 Scenario 1: req 0 with word 0x48656C; matcher model raises m_done=1, m_found=1 after 5 SEARCH cycles -> m_cs high 5 cycles, then resp_valid=0001 and resp_found=1 for one cycle.
REQ-037 Scenario 2: all four requesters valid continuously -> grants in order 0,1,2,3,0 with exactly one resp_valid per grant.
REQ-038 Scenario 3: matcher never asserts m_done, TIMEOUT_CYCLES=8 -> m_cs high exactly 8 cycles, then resp_timeout=1 and resp_found=0.
REQ-039 Scenario 4: m_done=1 asserted on the counter==TIMEOUT_CYCLES-1 cycle -> resp_timeout=0 and resp_found=m_found.
REQ-040 Scenario 5: rst asserted on the 3rd SEARCH cycle of req 2 -> no resp_valid, m_cs=0 on the next cycle, and the next grant goes to requester 0.
REQ-041 Scenario 6: req_word changes and a stray m_done arrive while the block is in IDLE -> m_word unchanged and no response.
